// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared loader state encoding and default address width
package mips_pkg;

    localparam int ADDR_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHECK,
        FINISH
    } ld_state_t;

endpackage

// File: rtl/prog_loader_packer.sv
// rtl/prog_loader_packer.sv - big-endian byte-to-word packer with XOR checksum accumulator
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clear         restart packing: byte position and accumulator cleared
//   byte_en       accept byte_in this cycle
//   byte_in       payload byte
//   word_next     packed word including byte_in (valid when last_byte)
//   acc           XOR of all data bytes accepted since clear
//   last_byte     byte_en on the fourth byte of a word
module prog_loader_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic [7:0]  acc,
    output logic        last_byte
);

    // Only the three earlier bytes are stored; the fourth arrives on byte_in.
    logic [23:0] word_q;
    logic [1:0]  byte_cnt_q;
    logic [7:0]  acc_q;

    assign word_next = {word_q, byte_in};
    assign acc       = acc_q;
    assign last_byte = byte_en && (byte_cnt_q == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
            acc_q      <= '0;
        end else if (clear) begin
            byte_cnt_q <= '0;
            acc_q      <= '0;
        end else if (byte_en) begin
            word_q     <= {word_q[15:0], byte_in};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            acc_q      <= acc_q ^ byte_in;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream instruction memory loader with XOR checksum and CPU hold
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, word_count        begin a load of word_count words (0 = 2^ADDR_W)
//   in_valid/in_data/in_ready byte-stream input handshake
//   mem_we/mem_addr/mem_wdata instruction memory write port
//   cpu_hold                 holds the CPU in clear until a clean load completes
//   busy, done, err          load status; err is sticky checksum mismatch
module prog_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] last_idx_q;
    logic              err_q;
    logic              hold_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic        accept;
    logic        load_start;
    logic [31:0] pk_word_next;
    logic [7:0]  pk_acc;
    logic        pk_last;

    assign in_ready   = (state_q == RECV) || (state_q == CHECK);
    assign accept     = in_valid && in_ready;
    assign load_start = (state_q == IDLE) && start;

    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign err       = err_q;
    assign cpu_hold  = hold_q;

    prog_loader_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (load_start),
        .byte_en   (accept && (state_q == RECV)),
        .byte_in   (in_data),
        .word_next (pk_word_next),
        .acc       (pk_acc),
        .last_byte (pk_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = RECV;
            RECV:    if (pk_last) state_d = WRITE;
            WRITE:   state_d = (idx_q == last_idx_q) ? CHECK : RECV;
            CHECK:   if (accept)  state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            last_idx_q <= '0;
            err_q      <= 1'b0;
            hold_q     <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load_start) begin
                // count-1 wraps a count of 0 to the all-ones index, i.e. 2^ADDR_W words.
                last_idx_q <= word_count - 1'b1;
                idx_q      <= '0;
                err_q      <= 1'b0;
                hold_q     <= 1'b1;
            end
            // Capture the write so address/data stay stable outside WRITE.
            if (pk_last) begin
                addr_q  <= idx_q;
                wdata_q <= pk_word_next;
            end
            if (state_q == WRITE && idx_q != last_idx_q) begin
                idx_q <= idx_q + 1'b1;
            end
            if (state_q == CHECK && accept && in_data != pk_acc) begin
                err_q <= 1'b1;
            end
            if (state_q == FINISH) begin
                hold_q <= err_q;
            end
        end
    end

endmodule
